pll_rst_seq: RTL and testbench
==============================

Name: pll_rst_seq

Overview:
- Power-up and recovery sequencer for the system PLL and the derived reset tree.
- Pulses PLL areset, waits for PLL lock with a timeout, and requires lock to stay stable before releasing resets.
- Releases the clk_sys-domain reset, then the clk_slow-domain reset, in order.
- Monitors for loss of lock in every post-lock state, and supports a software-requested full restart.
- Runs on the raw board clock mclk0, never on a PLL output, and sits between the board reset pin and the PLL/reset distribution.

Parameters:
- ARST_CYC, 16, mclk0 cycles that pll_areset is held high per attempt (≥1).
- LOCK_TO, 50000, mclk0 cycles allowed in WAIT_LOCK before a timeout (≥2).
- STABLE_CYC, 1024, consecutive synchronized-locked cycles required before any reset is released (≥1).
- GAP_CYC, 8, cycles between rst_sys_n release and rst_slow_n release (≥1).
- MAX_RETRY, 3, lock timeouts tolerated before error (1..15).
- CNT_W, 16, width of the shared cycle counter; must hold max(ARST_CYC, LOCK_TO, STABLE_CYC, GAP_CYC).

Ports:
- mclk0, input, 1, free-running board clock; the only clock in the block.
- hrst, input, 1, asynchronous active-high reset; assertion is async, release is assumed synchronous to mclk0 upstream.
- pll_locked, input, 1, PLL lock indicator, asynchronous to mclk0.
- soft_rst, input, 1, single-cycle restart request, synchronous to mclk0.
- pll_areset, output, 1, PLL reset, active high.
- rst_sys_n, output, 1, reset for the clk_sys domain, active low; the destination domain synchronizes it.
- rst_slow_n, output, 1, reset for the clk_slow domain, active low.
- ready, output, 1, high only in RUN.
- pll_err, output, 1, sticky lock-failure flag.
- lock_lost, output, 1, one-cycle pulse when lock drops after reset release.
- retry_cnt, output, 4, number of lock timeouts since the last hrst or soft_rst.

Behaviour:
- Reset values (hrst high): state=ARST, counter=0, pll_areset=1, rst_sys_n=0, rst_slow_n=0, ready=0, pll_err=0, lock_lost=0, retry_cnt=0, locked_sync=0.
- pll_locked passes through a 2-flop synchronizer (locked_sync), adding 2 cycles of latency.
- All outputs are registered and change on the same edge as the state transition that defines them.
- The counter clears on every state entry. "Exit after N" means the transition occurs on the N-th edge after the entry edge.

States:
- ARST:
  - pll_areset=1; exit after ARST_CYC edges to WAIT_LOCK.
  - pll_areset falls on that exit edge.
- WAIT_LOCK:
  - If locked_sync=1, go to STABLE on the next edge.
  - Otherwise, on the LOCK_TO-th edge: timeout, retry_cnt+1.
  - If the new retry_cnt == MAX_RETRY, go to ERR; otherwise go to ARST.
- STABLE:
  - If locked_sync=0 on any edge, go to WAIT_LOCK; retry_cnt is not incremented.
  - After STABLE_CYC edges, go to REL.
- REL:
  - rst_sys_n=1 on the entry edge.
  - After GAP_CYC edges, go to RUN.
- RUN:
  - rst_slow_n=1 and ready=1 on the entry edge; stays in RUN while locked_sync=1.
- ERR:
  - pll_areset=1, pll_err=1, all resets asserted.
  - Only soft_rst or hrst exits this state.

Lock loss:
- locked_sync=0 in REL or RUN → next edge: rst_sys_n=0, rst_slow_n=0, ready=0, lock_lost=1 for one cycle, go to ARST.
- retry_cnt is unchanged.

soft_rst:
- In any state, including ERR: next edge goes to ARST, clears retry_cnt and pll_err, and asserts pll_areset.
- Resets are asserted; lock_lost is not pulsed.

Priority when events coincide:
- soft_rst > lock loss > timeout > normal progression.
- Timeout and locked_sync=1 on the same edge in WAIT_LOCK: locked wins, go to STABLE, no retry.

Output rules:
- rst_sys_n and rst_slow_n are never released while pll_areset=1.
- rst_slow_n is never 1 while rst_sys_n=0.

Decomposition:
- Shared package pll_rst_pkg holds the state encoding (ARST, WAIT_LOCK, STABLE, REL, RUN, ERR; one-hot 6-bit) and the default timing constants, reused by the clock top and the bench.
- One natural sub-module: sync2 (generic 2-flop synchronizer, async active-high reset to 0), used for pll_locked.

Test Plan:
Bench parameters: ARST_CYC=4, LOCK_TO=20, STABLE_CYC=8, GAP_CYC=3, MAX_RETRY=2.
1. Clean bring-up: release hrst with pll_locked=1 constant → pll_areset falls at edge 4; rst_sys_n rises at edge 13; rst_slow_n and ready rise at edge 16; retry_cnt=0.
2. Lock never arrives: pll_locked=0 → timeout at edge 24 (retry_cnt=1, back to ARST); second timeout at edge 48 → pll_err=1, retry_cnt=2, pll_areset=1, all resets held. Then soft_rst → pll_err=0, retry_cnt=0, new ARST.
3. Lock chatter: drop pll_locked for 1 cycle mid-STABLE → returns to WAIT_LOCK, STABLE count restarts, no retry increment; rst_sys_n stays 0 throughout.
4. Lock loss in RUN: drop pll_locked → 3 edges later (2 sync + 1) rst_sys_n=0, rst_slow_n=0, ready=0, single-cycle lock_lost; full resequence follows when lock returns.
5. soft_rst in REL coinciding with lock loss → ARST entered with lock_lost=0; retry_cnt cleared.
6. hrst asserted asynchronously mid-RUN → all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: one-hot state encoding,
// default timing constants and a small state-classification helper.
package pll_rst_pkg;

  typedef enum logic [5:0] {
    ST_ARST      = 6'b000001,
    ST_WAIT_LOCK = 6'b000010,
    ST_STABLE    = 6'b000100,
    ST_REL       = 6'b001000,
    ST_RUN       = 6'b010000,
    ST_ERR       = 6'b100000
  } state_t;

  localparam int ARST_CYC_DEF   = 16;
  localparam int LOCK_TO_DEF    = 50000;
  localparam int STABLE_CYC_DEF = 1024;
  localparam int GAP_CYC_DEF    = 8;
  localparam int MAX_RETRY_DEF  = 3;
  localparam int CNT_W_DEF      = 16;

  // States in which at least one downstream reset has been released.
  function automatic logic is_post_lock(input state_t s);
    return (s == ST_REL) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high clear to zero.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// Power-up / recovery sequencer: pulses PLL areset, waits for a stable lock,
// then releases the clk_sys and clk_slow resets in order. Runs on mclk0 only.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int ARST_CYC   = ARST_CYC_DEF,
  parameter int LOCK_TO    = LOCK_TO_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int GAP_CYC    = GAP_CYC_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       mclk0,
  input  logic       hrst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_areset,
  output logic       rst_sys_n,
  output logic       rst_slow_n,
  output logic       ready,
  output logic       pll_err,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam logic [CNT_W-1:0] ARST_LAST   = CNT_W'(ARST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  logic             locked_sync;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       retry_nx;
  logic             err_nx;
  logic             lost_nx;
  logic             enter;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (mclk0),
    .rst (hrst),
    .d   (pll_locked),
    .q   (locked_sync)
  );

  // Next state with priority soft_rst > lock loss > timeout > progression.
  // A lock seen on the timeout edge wins, so the timeout test sits in the else.
  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    err_nx   = pll_err;
    lost_nx  = 1'b0;
    enter    = 1'b0;
    cnt_nx   = cnt;

    if (soft_rst) begin
      state_nx = ST_ARST;
      retry_nx = 4'd0;
      err_nx   = 1'b0;
      enter    = 1'b1;
    end else if (is_post_lock(state) && !locked_sync) begin
      state_nx = ST_ARST;
      lost_nx  = 1'b1;
    end else begin
      case (state)
        ST_ARST: begin
          if (cnt == ARST_LAST) state_nx = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_sync) begin
            state_nx = ST_STABLE;
          end else if (cnt == LOCK_LAST) begin
            retry_nx = retry_cnt + 4'd1;
            if (retry_nx == RETRY_MAX) begin
              state_nx = ST_ERR;
              err_nx   = 1'b1;
            end else begin
              state_nx = ST_ARST;
            end
          end
        end
        ST_STABLE: begin
          if (!locked_sync)              state_nx = ST_WAIT_LOCK;
          else if (cnt == STABLE_LAST)   state_nx = ST_REL;
        end
        ST_REL: begin
          if (cnt == GAP_LAST) state_nx = ST_RUN;
        end
        ST_RUN: begin
          state_nx = ST_RUN;
        end
        ST_ERR: begin
          err_nx = 1'b1;
        end
        default: begin
          state_nx = ST_ARST;
        end
      endcase
    end

    if (state_nx != state) enter = 1'b1;

    if (enter)                                    cnt_nx = '0;
    else if ((state == ST_RUN) || (state == ST_ERR)) cnt_nx = cnt;
    else                                          cnt_nx = cnt + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as the transition; deriving the resets from the state alone keeps them
  // ordered and never released while areset is high.
  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) begin
      state      <= ST_ARST;
      cnt        <= '0;
      pll_areset <= 1'b1;
      rst_sys_n  <= 1'b0;
      rst_slow_n <= 1'b0;
      ready      <= 1'b0;
      pll_err    <= 1'b0;
      lock_lost  <= 1'b0;
      retry_cnt  <= 4'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pll_areset <= (state_nx == ST_ARST) || (state_nx == ST_ERR);
      rst_sys_n  <= (state_nx == ST_REL) || (state_nx == ST_RUN);
      rst_slow_n <= (state_nx == ST_RUN);
      ready      <= (state_nx == ST_RUN);
      pll_err    <= err_nx;
      lock_lost  <= lost_nx;
      retry_cnt  <= retry_nx;
    end
  end

  a_no_rel_in_areset: assert property (@(posedge mclk0) disable iff (hrst)
    !(pll_areset && (rst_sys_n || rst_slow_n)));

  a_slow_after_sys: assert property (@(posedge mclk0) disable iff (hrst)
    !(rst_slow_n && !rst_sys_n));

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed self-checking bench for pll_rst_seq with shortened timing so every
// scenario completes in a few dozen mclk0 edges.
module tb_pll_rst_seq;

  logic       mclk0;
  logic       hrst;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_areset;
  logic       rst_sys_n;
  logic       rst_slow_n;
  logic       ready;
  logic       pll_err;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed outputs packed as {areset, sys_n, slow_n, ready, err, lost, retry[3:0]}.
  logic [9:0] obs;
  assign obs = {pll_areset, rst_sys_n, rst_slow_n, ready, pll_err, lock_lost, retry_cnt};

  pll_rst_seq #(
    .ARST_CYC   (4),
    .LOCK_TO    (20),
    .STABLE_CYC (8),
    .GAP_CYC    (3),
    .MAX_RETRY  (2),
    .CNT_W      (16)
  ) dut (
    .mclk0      (mclk0),
    .hrst       (hrst),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .pll_areset (pll_areset),
    .rst_sys_n  (rst_sys_n),
    .rst_slow_n (rst_slow_n),
    .ready      (ready),
    .pll_err    (pll_err),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt)
  );

  initial mclk0 = 1'b0;
  always #5 mclk0 = ~mclk0;

  task automatic tick(input int n);
    repeat (n) @(posedge mclk0);
    #1;
  endtask

  // Holds hrst for a few edges and releases it just after an edge, so the
  // next posedge is edge 1 of the sequence.
  task automatic do_reset(input logic lk);
    hrst       = 1'b1;
    soft_rst   = 1'b0;
    pll_locked = lk;
    tick(3);
    hrst = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    hrst       = 1'b1;
    soft_rst   = 1'b0;
    pll_locked = 1'b1;
    tick(2);
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL reset_values: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_bringup();
    logic [9:0] exp;
    do_reset(1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      exp = {(e < 4), (e >= 13), (e >= 16), (e >= 16), 1'b0, 1'b0, 4'd0};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("[TB] FAIL bringup edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_timeout_err();
    logic [9:0] exp;
    logic [3:0] rc;
    do_reset(1'b0);
    for (int e = 1; e <= 50; e++) begin
      tick(1);
      rc  = (e >= 48) ? 4'd2 : (e >= 24) ? 4'd1 : 4'd0;
      exp = {(e < 4) || (e >= 24 && e < 28) || (e >= 48), 1'b0, 1'b0, 1'b0,
             (e >= 48), 1'b0, rc};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("[TB] FAIL timeout edge %0d: got %b want %b", e, obs, exp);
      end
    end
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL err_soft_clear: got %b want %b", obs, exp);
    end
    tick(3);
    n_cmp++;
    if (pll_areset !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rearst_hold: got %b want 1", pll_areset);
    end
    tick(1);
    n_cmp++;
    if (pll_areset !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rearst_release: got %b want 0", pll_areset);
    end
  endtask

  task automatic test_chatter();
    logic [9:0] exp;
    do_reset(1'b1);
    for (int e = 1; e <= 23; e++) begin
      tick(1);
      exp = {(e < 4), (e >= 19), (e >= 22), (e >= 22), 1'b0, 1'b0, 4'd0};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("[TB] FAIL chatter edge %0d: got %b want %b", e, obs, exp);
      end
      if (e == 7) pll_locked = 1'b0;
      if (e == 8) pll_locked = 1'b1;
    end
  endtask

  task automatic test_run_lock_loss();
    logic [9:0] exp;
    do_reset(1'b1);
    tick(17);
    pll_locked = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      exp = {(e >= 3 && e < 7), (e < 3 || e >= 16), (e < 3 || e >= 19),
             (e < 3 || e >= 19), 1'b0, (e == 3), 4'd0};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("[TB] FAIL run_loss edge %0d: got %b want %b", e, obs, exp);
      end
      if (e == 4) pll_locked = 1'b1;
    end
  endtask

  task automatic test_soft_in_rel();
    logic [9:0] exp;
    do_reset(1'b0);
    tick(24);
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL rel_setup_timeout: got %b want %b", obs, exp);
    end
    pll_locked = 1'b1;
    tick(12);
    pll_locked = 1'b0;
    tick(2);
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL rel_setup_rel: got %b want %b", obs, exp);
    end
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL soft_vs_loss: got %b want %b", obs, exp);
    end
    tick(1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL soft_vs_loss_next: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_async_hrst();
    logic [9:0] exp;
    do_reset(1'b1);
    tick(18);
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL hrst_pre_run: got %b want %b", obs, exp);
    end
    #3;
    hrst = 1'b1;
    #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL hrst_async: got %b want %b", obs, exp);
    end
    tick(1);
    hrst = 1'b0;
  endtask

  initial begin
    hrst       = 1'b1;
    soft_rst   = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_bringup();
    test_timeout_err();
    test_chatter();
    test_run_lock_loss();
    test_soft_in_rel();
    test_async_hrst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
